pipe_ctrl_unit: RTL and testbench

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/pipe_ctrl_unit_decode.sv | 77 +++++++
 rtl/pipe_ctrl_unit.sv | 134 +++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: opcodes, ALU-op codes,
// control-field bit positions and the per-stage control bundle.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RFUNCT = 2'b10,
        ALU_IFUNCT = 2'b11
    } aluOp_e;

    // ex_ctrl is {alu_src, alu_op}; alu_src sits just above the alu_op field
    localparam int EX_ALU_OP_LSB     = 0;
    localparam int EX_ALU_OP_BITS    = 2;
    localparam int MEM_READ_BIT      = 2;
    localparam int MEM_WRITE_BIT     = 1;
    localparam int MEM_BRANCH_BIT    = 0;
    localparam int WB_MEM_TO_REG_BIT = 1;
    localparam int WB_REG_WRITE_BIT  = 0;

    function automatic int exAluSrcBit(input int aluOpW);
        return aluOpW;
    endfunction

    typedef struct packed {
        logic       valid;
        logic       aluSrc;
        logic [1:0] aluOp;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       memToReg;
        logic       regWrite;
        logic [4:0] rd;
    } stageCtrl_t;

    localparam stageCtrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational instruction decode: control fields, destination register and
// which source registers the instruction actually reads.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] instId,
    input  logic        idValid,
    output logic        aluSrc,
    output logic [1:0]  aluOp,
    output logic        memRead,
    output logic        memWrite,
    output logic        branch,
    output logic        memToReg,
    output logic        regWrite,
    output logic [4:0]  rd,
    output logic        usesRs1,
    output logic        usesRs2,
    output logic        illegal
);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    always_comb begin
        aluSrc   = 1'b0;
        aluOp    = ALU_ADD;
        memRead  = 1'b0;
        memWrite = 1'b0;
        branch   = 1'b0;
        memToReg = 1'b0;
        regWrite = 1'b0;
        usesRs1  = 1'b0;
        usesRs2  = 1'b0;
        illegal  = 1'b0;
        if (idValid) begin
            case (instId[6:0])
                OPC_RTYPE: begin
                    aluOp    = ALU_RFUNCT;
                    regWrite = 1'b1;
                    usesRs1  = 1'b1;
                    usesRs2  = 1'b1;
                end
                OPC_ITYPE: begin
                    aluSrc   = 1'b1;
                    aluOp    = ALU_IFUNCT;
                    regWrite = 1'b1;
                    usesRs1  = 1'b1;
                end
                OPC_LOAD: begin
                    aluSrc   = 1'b1;
                    memRead  = 1'b1;
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                    usesRs1  = 1'b1;
                end
                OPC_STORE: begin
                    aluSrc   = 1'b1;
                    memWrite = 1'b1;
                    usesRs1  = 1'b1;
                    usesRs2  = 1'b1;
                end
                OPC_BRANCH: begin
                    aluOp    = ALU_BRANCH;
                    branch   = 1'b1;
                    usesRs1  = 1'b1;
                    usesRs2  = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
        // stores and branches carry immediate bits in [11:7], not a register
        rd = regWrite ? instId[11:7] : 5'd0;
    end

    logic unusedInstBits;
    assign unusedInstBits = ^instId[31:12];

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Control pipeline for a 5-stage core: ID/EX, EX/MEM and MEM/WB control
// registers, load-use hazard detection and a saturating bubble counter.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int HAZ_DET = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_id,
    input  logic                 id_valid,
    input  logic                 freeze,
    input  logic                 flush,
    output logic [ALUOP_W:0]     ex_ctrl,
    output logic [2:0]           mem_ctrl,
    output logic [1:0]           wb_ctrl,
    output logic [4:0]           rd_ex,
    output logic [4:0]           rd_mem,
    output logic [4:0]           rd_wb,
    output logic                 hazard_stall,
    output logic                 illegal_id,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam bit HazEn = (HAZ_DET != 0);

    logic       decAluSrc, decMemRead, decMemWrite, decBranch;
    logic       decMemToReg, decRegWrite, decUsesRs1, decUsesRs2, decIllegal;
    logic [1:0] decAluOp;
    logic [4:0] decRd;

    ctrl_decode uDecode (
        .instId   (inst_id),
        .idValid  (id_valid),
        .aluSrc   (decAluSrc),
        .aluOp    (decAluOp),
        .memRead  (decMemRead),
        .memWrite (decMemWrite),
        .branch   (decBranch),
        .memToReg (decMemToReg),
        .regWrite (decRegWrite),
        .rd       (decRd),
        .usesRs1  (decUsesRs1),
        .usesRs2  (decUsesRs2),
        .illegal  (decIllegal)
    );

    stageCtrl_t decoded;
    stageCtrl_t idEx, exMem, memWb;
    logic [CNT_W-1:0] stallCnt;

    always_comb begin
        decoded          = BUBBLE;
        decoded.valid    = id_valid && !decIllegal;
        decoded.aluSrc   = decAluSrc;
        decoded.aluOp    = decAluOp;
        decoded.memRead  = decMemRead;
        decoded.memWrite = decMemWrite;
        decoded.branch   = decBranch;
        decoded.memToReg = decMemToReg;
        decoded.regWrite = decRegWrite;
        decoded.rd       = decRd;
    end

    // Load-use: the load in EX cannot forward its data to the instruction in ID
    logic rs1Hit, rs2Hit, loadUse;
    assign rs1Hit  = decUsesRs1 && (idEx.rd == inst_id[19:15]);
    assign rs2Hit  = decUsesRs2 && (idEx.rd == inst_id[24:20]);
    assign loadUse = HazEn && id_valid && idEx.valid && idEx.memRead
                     && (idEx.rd != 5'd0) && (rs1Hit || rs2Hit);

    assign hazard_stall = loadUse && !flush;
    assign illegal_id   = decIllegal;

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the pre-edge value of the stage ahead of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idEx     <= BUBBLE;
            exMem    <= BUBBLE;
            memWb    <= BUBBLE;
            stallCnt <= '0;
        end else if (freeze) begin
            idEx     <= idEx;
            exMem    <= exMem;
            memWb    <= memWb;
            stallCnt <= stallCnt;
        end else if (flush) begin
            idEx  <= BUBBLE;
            exMem <= BUBBLE;
            memWb <= exMem;
        end else if (loadUse) begin
            idEx     <= BUBBLE;
            exMem    <= idEx;
            memWb    <= exMem;
            stallCnt <= (stallCnt == '1) ? stallCnt : stallCnt + CNT_W'(1);
        end else begin
            idEx  <= decoded;
            exMem <= idEx;
            memWb <= exMem;
        end
    end

    always_comb begin
        ex_ctrl                                    = '0;
        ex_ctrl[exAluSrcBit(ALUOP_W)]              = idEx.aluSrc;
        ex_ctrl[EX_ALU_OP_LSB +: EX_ALU_OP_BITS]   = idEx.aluOp;
    end

    always_comb begin
        mem_ctrl                 = '0;
        mem_ctrl[MEM_READ_BIT]   = exMem.memRead;
        mem_ctrl[MEM_WRITE_BIT]  = exMem.memWrite;
        mem_ctrl[MEM_BRANCH_BIT] = exMem.branch;
    end

    always_comb begin
        wb_ctrl                    = '0;
        wb_ctrl[WB_MEM_TO_REG_BIT] = memWb.memToReg;
        wb_ctrl[WB_REG_WRITE_BIT]  = memWb.regWrite;
    end

    assign rd_ex     = idEx.rd;
    assign rd_mem    = exMem.rd;
    assign rd_wb     = memWb.rd;
    assign stall_cnt = stallCnt;

    // Downstream stages carry the full bundle; fields no later stage needs are pruned
    logic unusedStageBits;
    assign unusedStageBits = ^{exMem, memWb};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode latency, load-use stalls, flush,
// freeze, reset and counter saturation (second instance with CNT_W=2).
module tb_pipe_ctrl_unit;

    logic        clk;
    logic        rst;
    logic [31:0] inst_id;
    logic        id_valid;
    logic        freeze;
    logic        flush;

    logic [2:0]  ex_ctrl, satEx;
    logic [2:0]  mem_ctrl, satMem;
    logic [1:0]  wb_ctrl, satWb;
    logic [4:0]  rd_ex, rd_mem, rd_wb, satRdEx, satRdMem, satRdWb;
    logic        hazard_stall, illegal_id, satHaz, satIll;
    logic [15:0] stall_cnt;
    logic [1:0]  satCnt;

    int testsRun = 0;
    int testsFailed = 0;

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .id_valid(id_valid),
        .freeze(freeze), .flush(flush), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
        .wb_ctrl(wb_ctrl), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .hazard_stall(hazard_stall), .illegal_id(illegal_id), .stall_cnt(stall_cnt)
    );

    pipe_ctrl_unit #(.CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .inst_id(inst_id), .id_valid(id_valid),
        .freeze(freeze), .flush(flush), .ex_ctrl(satEx), .mem_ctrl(satMem),
        .wb_ctrl(satWb), .rd_ex(satRdEx), .rd_mem(satRdMem), .rd_wb(satRdWb),
        .hazard_stall(satHaz), .illegal_id(satIll), .stall_cnt(satCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encR(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd4, rs1, 3'b010, rd, opc};
    endfunction

    function automatic logic [31:0] encS(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, 5'd9, 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, 5'd8, 7'b1100011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic [31:0] inst);
        inst_id  = inst;
        id_valid = 1'b1;
        #1;
    endtask

    task automatic idle();
        inst_id  = 32'd0;
        id_valid = 1'b0;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        idle();
        step();
        rst = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " ex_ctrl"},   {29'd0, ex_ctrl},   32'd0);
        check({tag, " mem_ctrl"},  {29'd0, mem_ctrl},  32'd0);
        check({tag, " wb_ctrl"},   {30'd0, wb_ctrl},   32'd0);
        check({tag, " rd_ex"},     {27'd0, rd_ex},     32'd0);
        check({tag, " rd_mem"},    {27'd0, rd_mem},    32'd0);
        check({tag, " rd_wb"},     {27'd0, rd_wb},     32'd0);
        check({tag, " stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; inst_id = 32'd0; id_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        checkAllZero("reset");
        check("reset sat_cnt", {30'd0, satCnt}, 32'd0);

        // add x3,x1,x2 followed by addi x4,x1,4
        setId(encR(5'd3, 5'd1, 5'd2));
        check("add illegal", {31'd0, illegal_id}, 32'd0);
        check("add hazard", {31'd0, hazard_stall}, 32'd0);
        step();
        check("add ex_ctrl N+1", {29'd0, ex_ctrl}, 32'h2);
        check("add rd_ex", {27'd0, rd_ex}, 32'd3);
        setId(encI(7'b0010011, 5'd4, 5'd1));
        step();
        check("add mem_ctrl N+2", {29'd0, mem_ctrl}, 32'd0);
        check("add rd_mem", {27'd0, rd_mem}, 32'd3);
        check("addi ex_ctrl", {29'd0, ex_ctrl}, 32'h7);
        check("addi rd_ex", {27'd0, rd_ex}, 32'd4);
        idle();
        step();
        check("add wb_ctrl N+3", {30'd0, wb_ctrl}, 32'h1);
        check("add rd_wb", {27'd0, rd_wb}, 32'd3);
        check("idle ex_ctrl", {29'd0, ex_ctrl}, 32'd0);
        check("addi rd_mem", {27'd0, rd_mem}, 32'd4);
        step();
        check("addi rd_wb", {27'd0, rd_wb}, 32'd4);

        // lw x5,0(x1) then add x6,x5,x2: one bubble
        doReset();
        setId(encI(7'b0000011, 5'd5, 5'd1));
        step();
        check("lw ex_ctrl", {29'd0, ex_ctrl}, 32'h4);
        check("lw rd_ex", {27'd0, rd_ex}, 32'd5);
        setId(encR(5'd6, 5'd5, 5'd2));
        check("lu hazard", {31'd0, hazard_stall}, 32'd1);
        step();
        check("lu bubble ex_ctrl", {29'd0, ex_ctrl}, 32'd0);
        check("lu bubble rd_ex", {27'd0, rd_ex}, 32'd0);
        check("lu lw mem_ctrl", {29'd0, mem_ctrl}, 32'h4);
        check("lu stall_cnt", {16'd0, stall_cnt}, 32'd1);
        check("lu hazard cleared", {31'd0, hazard_stall}, 32'd0);
        step();
        check("lu add late ex_ctrl", {29'd0, ex_ctrl}, 32'h2);
        check("lu add rd_ex", {27'd0, rd_ex}, 32'd6);
        check("lu lw wb_ctrl", {30'd0, wb_ctrl}, 32'h3);
        check("lu lw rd_wb", {27'd0, rd_wb}, 32'd5);
        idle();
        step();
        check("lu stall_cnt hold", {16'd0, stall_cnt}, 32'd1);

        // lw x0 never creates a hazard
        doReset();
        setId(encI(7'b0000011, 5'd0, 5'd1));
        step();
        check("lw x0 rd_ex", {27'd0, rd_ex}, 32'd0);
        setId(encR(5'd6, 5'd0, 5'd2));
        check("x0 hazard", {31'd0, hazard_stall}, 32'd0);
        step();
        check("x0 add on time", {29'd0, ex_ctrl}, 32'h2);
        check("x0 stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // add, beq, lw x5 in flight; flush with a pending load-use in ID
        doReset();
        setId(encR(5'd3, 5'd1, 5'd2));
        step();
        setId(encB(5'd1, 5'd2));
        step();
        setId(encI(7'b0000011, 5'd5, 5'd1));
        step();
        check("fl beq mem_ctrl", {29'd0, mem_ctrl}, 32'h1);
        check("fl add wb_ctrl", {30'd0, wb_ctrl}, 32'h1);
        setId(encR(5'd6, 5'd5, 5'd2));
        check("fl hazard raw", {31'd0, hazard_stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("fl hazard masked", {31'd0, hazard_stall}, 32'd0);
        step();
        flush = 1'b0;
        idle();
        check("fl ex_ctrl", {29'd0, ex_ctrl}, 32'd0);
        check("fl mem_ctrl", {29'd0, mem_ctrl}, 32'd0);
        check("fl wb_ctrl beq", {30'd0, wb_ctrl}, 32'd0);
        check("fl rd_wb beq", {27'd0, rd_wb}, 32'd0);
        check("fl stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // freeze for 3 cycles with lw in ID/EX, then reset while frozen
        doReset();
        setId(encR(5'd3, 5'd1, 5'd2));
        step();
        setId(encI(7'b0000011, 5'd5, 5'd1));
        step();
        setId(encR(5'd6, 5'd5, 5'd2));
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("fz ex_ctrl", {29'd0, ex_ctrl}, 32'h4);
            check("fz rd_ex", {27'd0, rd_ex}, 32'd5);
            check("fz mem_ctrl", {29'd0, mem_ctrl}, 32'd0);
            check("fz rd_mem", {27'd0, rd_mem}, 32'd3);
            check("fz wb_ctrl", {30'd0, wb_ctrl}, 32'd0);
            check("fz stall_cnt", {16'd0, stall_cnt}, 32'd0);
            check("fz hazard", {31'd0, hazard_stall}, 32'd1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        freeze = 1'b0;
        checkAllZero("rst in freeze");
        check("rst in freeze hazard", {31'd0, hazard_stall}, 32'd0);
        idle();

        // five load-use pairs: 2-bit counter saturates at 3
        doReset();
        for (int i = 0; i < 5; i++) begin
            logic [4:0] r;
            logic [31:0] consumer;
            r = 5'(5 + i);
            case (i % 3)
                0:       consumer = encR(5'd6, r, 5'd2);
                1:       consumer = encS(5'd1, r);
                default: consumer = encB(5'd2, r);
            endcase
            setId(encI(7'b0000011, r, 5'd1));
            check("sat lw no hazard", {31'd0, hazard_stall}, 32'd0);
            step();
            setId(consumer);
            check("sat hazard", {31'd0, hazard_stall}, 32'd1);
            step();
            check("sat bubble", {29'd0, ex_ctrl}, 32'd0);
            check("sat cnt2", {30'd0, satCnt}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            check("sat cnt16", {16'd0, stall_cnt}, 32'(i + 1));
            step();
            if (i % 3 == 1) check("sw rd_ex", {27'd0, rd_ex}, 32'd0);
        end

        // unsupported opcode
        idle();
        inst_id = 32'h0000_03FF;
        #1;
        check("ill no valid", {31'd0, illegal_id}, 32'd0);
        setId(32'h0000_03FF);
        check("ill flag", {31'd0, illegal_id}, 32'd1);
        step();
        check("ill bubble ex", {29'd0, ex_ctrl}, 32'd0);
        check("ill bubble rd", {27'd0, rd_ex}, 32'd0);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
